// File: rtl/lb_tx_arbiter.sv
// -----------------------------------------------------------------------------
// lb_tx_arbiter
//
// Two-input Avalon-ST packet arbiter. It locks onto one sink port for a whole
// packet, from startofpacket to endofpacket, and forwards that packet's beats
// through a single output register. When both ports start a packet in the same
// idle cycle, round-robin on the last granted port decides which one goes.
// A beat that arrives while idle without startofpacket cannot belong to any
// packet. It is accepted, thrown away and counted in drop_cnt.
//
// Parameters
//   CNT_W               width of pkt_cnt0 / pkt_cnt1 / drop_cnt
//
// Ports
//   clk                 sole clock, rising edge
//   reset               asynchronous, active-low
//   in0_* / in1_*       Avalon-ST sinks (data, valid, ready, sop, eop, empty,
//                       error). A beat transfers when valid && ready.
//   out_*               Avalon-ST source, registered (latency 1 from the sinks)
//   out_ready           downstream ready
//   pkt_cnt0/pkt_cnt1   packets forwarded per port (wrap)
//   drop_cnt            beats discarded while idle (saturating)
// -----------------------------------------------------------------------------
module lb_tx_arbiter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,

  input  logic [31:0]      in0_data,
  input  logic             in0_valid,
  output logic             in0_ready,
  input  logic             in0_startofpacket,
  input  logic             in0_endofpacket,
  input  logic [1:0]       in0_empty,
  input  logic             in0_error,

  input  logic [31:0]      in1_data,
  input  logic             in1_valid,
  output logic             in1_ready,
  input  logic             in1_startofpacket,
  input  logic             in1_endofpacket,
  input  logic [1:0]       in1_empty,
  input  logic             in1_error,

  output logic [31:0]      out_data,
  output logic             out_valid,
  output logic             out_startofpacket,
  output logic             out_endofpacket,
  output logic [1:0]       out_empty,
  output logic             out_error,
  input  logic             out_ready,

  output logic [CNT_W-1:0] pkt_cnt0,
  output logic [CNT_W-1:0] pkt_cnt1,
  output logic [CNT_W-1:0] drop_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_t;

  state_t state, state_nx;
  logic   last_grant, last_grant_nx;

  logic   slot_free;
  logic   ready0_raw, ready1_raw;
  logic   cand0, cand1;
  logic   fwd0, fwd1;
  logic   drop0, drop1;

  // The output slot can take a new beat when it is empty or is being drained
  // in this same cycle.
  assign slot_free = !out_valid || out_ready;

  assign cand0 = in0_valid && in0_startofpacket;
  assign cand1 = in1_valid && in1_startofpacket;

  // ---------------------------------------------------------------------------
  // Next-state and sink-ready logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal this block writes gets a default first, so that no
    // path through the case leaves a value unassigned and infers a latch.
    state_nx      = state;
    last_grant_nx = last_grant;
    ready0_raw    = 1'b0;
    ready1_raw    = 1'b0;

    unique case (state)
      IDLE: begin
        // Arbitration cycle. Start-of-packet beats wait here, which creates
        // the one-cycle bubble. Beats without sop are accepted so they can
        // be dropped.
        ready0_raw = in0_valid && !in0_startofpacket;
        ready1_raw = in1_valid && !in1_startofpacket;
        if (cand0 && cand1) begin
          // last_grant == 1 means port 1 went last, so port 0 wins.
          state_nx = last_grant ? LOCK0 : LOCK1;
        end else if (cand0) begin
          state_nx = LOCK0;
        end else if (cand1) begin
          state_nx = LOCK1;
        end
      end

      LOCK0: begin
        ready0_raw = slot_free;
        if (in0_valid && slot_free && in0_endofpacket) begin
          state_nx      = IDLE;
          last_grant_nx = 1'b0;
        end
      end

      LOCK1: begin
        ready1_raw = slot_free;
        if (in1_valid && slot_free && in1_endofpacket) begin
          state_nx      = IDLE;
          last_grant_nx = 1'b1;
        end
      end

      default: state_nx = IDLE;
    endcase
  end

  // The sinks are not ready while reset is held, even though the FSM already
  // sits in IDLE and would otherwise offer to drop stray beats.
  assign in0_ready = ready0_raw && reset;
  assign in1_ready = ready1_raw && reset;

  // Transfer classification for this cycle.
  assign fwd0  = (state == LOCK0) && in0_valid && in0_ready;
  assign fwd1  = (state == LOCK1) && in1_valid && in1_ready;
  assign drop0 = (state == IDLE)  && in0_valid && in0_ready;
  assign drop1 = (state == IDLE)  && in1_valid && in1_ready;

  // ---------------------------------------------------------------------------
  // FSM state and round-robin pointer
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state is written only with non-blocking assignments,
    // so every flop samples the pre-edge values regardless of block order.
    if (!reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;   // port 0 wins the first tie after reset
    end else begin
      state      <= state_nx;
      last_grant <= last_grant_nx;
    end
  end

  // ---------------------------------------------------------------------------
  // Output stage: a single register slot. It loads on an accepted forwarded
  // beat. When it is drained and nothing replaces it, it empties. Otherwise
  // it holds, which keeps data and qualifiers stable under backpressure.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: the data-path fields are reset too, not only out_valid.
      // Downstream then sees a defined all-zero beat while idle after reset.
      out_valid         <= 1'b0;
      out_data          <= '0;
      out_startofpacket <= 1'b0;
      out_endofpacket   <= 1'b0;
      out_empty         <= '0;
      out_error         <= 1'b0;
    end else if (fwd0) begin
      out_valid         <= 1'b1;
      out_data          <= in0_data;
      out_startofpacket <= in0_startofpacket;
      out_endofpacket   <= in0_endofpacket;
      out_empty         <= in0_empty;
      out_error         <= in0_error;
    end else if (fwd1) begin
      out_valid         <= 1'b1;
      out_data          <= in1_data;
      out_startofpacket <= in1_startofpacket;
      out_endofpacket   <= in1_endofpacket;
      out_empty         <= in1_empty;
      out_error         <= in1_error;
    end else if (out_ready) begin
      out_valid         <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Statistics
  // ---------------------------------------------------------------------------
  logic [1:0]     drop_inc;
  logic [CNT_W:0] drop_sum;

  assign drop_inc = {1'b0, drop0} + {1'b0, drop1};
  // One extra bit catches the carry out, so the counter can clamp at all-ones.
  assign drop_sum = {1'b0, drop_cnt} + {{(CNT_W - 1){1'b0}}, drop_inc};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pkt_cnt0 <= '0;
      pkt_cnt1 <= '0;
      drop_cnt <= '0;
    end else begin
      // Packet counters wrap naturally.
      if (fwd0 && in0_endofpacket) pkt_cnt0 <= pkt_cnt0 + CNT_W'(1);
      if (fwd1 && in1_endofpacket) pkt_cnt1 <= pkt_cnt1 + CNT_W'(1);
      if (drop_sum[CNT_W]) drop_cnt <= '1;
      else                 drop_cnt <= drop_sum[CNT_W-1:0];
    end
  end

endmodule
